// File: rtl/key_search.sv
// key_search: sweeps 24-bit key candidates in ascending order. For each
// candidate it starts the ARC4 decrypt engine, waits for it to finish, then
// scans the length-prefixed plaintext memory. The first candidate whose
// plaintext is entirely printable is reported on key/key_valid.
// Optional feature: define KEY_SEARCH_CANCEL_EN to add a 'cancel' input that
// abandons a running search and returns to idle.
module key_search #(
  parameter logic [23:0] KEY_FIRST = 24'h000000,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
  parameter logic [7:0]  CHAR_MIN  = 8'h20,
  parameter logic [7:0]  CHAR_MAX  = 8'h7E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic [23:0] arc4_key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata
`ifdef KEY_SEARCH_CANCEL_EN
  ,
  input  logic        cancel
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_LEN,
    S_SCAN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t      r_state;
  logic        r_rdy;
  logic [23:0] r_key;
  logic        r_key_valid;
  logic        r_arc4_en;
  logic [23:0] r_arc4_key;
  logic [7:0]  r_pt_addr;
  logic [23:0] r_cand;
  logic [7:0]  r_len;
  logic        r_len_wait;   // first RD_LEN cycle: memory still fetching address 0
  logic [7:0]  r_rd_addr;    // address whose data is on pt_rddata this cycle

  logic w_char_ok;
  logic w_cancel;

  assign w_char_ok = (pt_rddata >= CHAR_MIN) && (pt_rddata <= CHAR_MAX);

`ifdef KEY_SEARCH_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign rdy       = r_rdy;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign arc4_en   = r_arc4_en;
  assign arc4_key  = r_arc4_key;
  assign pt_addr   = r_pt_addr;

  // Search FSM: candidate sweep, ARC4 handshake and pipelined plaintext scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdy       <= 1'b1;
      r_key       <= 24'h000000;
      r_key_valid <= 1'b0;
      r_arc4_en   <= 1'b0;
      r_arc4_key  <= 24'h000000;
      r_pt_addr   <= 8'h00;
      r_cand      <= 24'h000000;
      r_len       <= 8'h00;
      r_len_wait  <= 1'b0;
      r_rd_addr   <= 8'h00;
    end else if (w_cancel && (r_state != S_IDLE)) begin
      // Abandon the search; a running ARC4 job is simply left to finish.
      r_arc4_en   <= 1'b0;
      r_key       <= r_cand;
      r_key_valid <= 1'b0;
      r_rdy       <= 1'b1;
      r_state     <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_rdy       <= 1'b0;
            r_key_valid <= 1'b0;
            r_cand      <= KEY_FIRST;
            r_state     <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          if (arc4_rdy) begin
            r_arc4_key <= r_cand;
            r_arc4_en  <= 1'b1;
            r_state    <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          // Start pulse is one cycle wide; then wait for the engine to drop rdy.
          r_arc4_en <= 1'b0;
          if (!arc4_rdy) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (arc4_rdy) begin
            r_pt_addr  <= 8'h00;
            r_len_wait <= 1'b1;
            r_state    <= S_RD_LEN;
          end
        end

        S_RD_LEN: begin
          if (r_len_wait) begin
            r_len_wait <= 1'b0;
          end else if (pt_rddata == 8'h00) begin
            r_state <= S_PASS;
          end else begin
            r_len     <= pt_rddata;
            r_pt_addr <= 8'h01;
            r_rd_addr <= 8'h00;
            r_state   <= S_SCAN;
          end
        end

        S_SCAN: begin
          // r_rd_addr == 0 marks the pipeline-fill cycle: data is still the
          // length byte, so nothing is checked.
          if ((r_rd_addr != 8'h00) && !w_char_ok) begin
            r_state <= S_FAIL;
          end else if ((r_rd_addr != 8'h00) && (r_rd_addr == r_len)) begin
            r_state <= S_PASS;
          end else begin
            if (r_pt_addr != r_len) begin
              r_pt_addr <= r_pt_addr + 8'h01;
            end
            r_rd_addr <= r_pt_addr;
          end
        end

        S_PASS: begin
          r_key       <= r_cand;
          r_key_valid <= 1'b1;
          r_rdy       <= 1'b1;
          r_state     <= S_IDLE;
        end

        S_FAIL: begin
          if (r_cand == KEY_LAST) begin
            r_key       <= r_cand;
            r_key_valid <= 1'b0;
            r_rdy       <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cand  <= r_cand + 24'h000001;
            r_state <= S_LAUNCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
